// File: rtl/mul_sa_if.sv
// Handshake and operand/result bundle between the modular-multiply controller and mul_sa.
// The master drives request and operands; the slave returns ack, FSM state and product.
interface mul_sa_if #(
  parameter int MSB = 7
);
  logic             enable;
  logic             req;
  logic             ack;
  logic [1:0]       cst;
  logic [1:0]       nst;
  logic [MSB:0]     rx_data_1;
  logic [MSB:0]     rx_data_2;
  logic [2*MSB+1:0] tx_data;

  modport master (
    output enable, req, rx_data_1, rx_data_2,
    input  ack, cst, nst, tx_data
  );

  modport slave (
    input  enable, req, rx_data_1, rx_data_2,
    output ack, cst, nst, tx_data
  );
endinterface

// File: rtl/mul_sa.sv
// Sequential shift-add unsigned multiplier feeding the modular-remainder stage.
// Optional macro MUL_EARLY_EXIT_EN ends the loop once the multiplier has shifted to zero.
module mul_sa #(
  parameter int MSB = 7
) (
  input  logic     clk0,
  input  logic     rstn,
  mul_sa_if.slave  bus
);

  localparam int W  = MSB + 1;
  localparam int CW = $clog2(MSB + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_IF   = 2'b11,
    ST_CALC = 2'b10
  } state_t;

  state_t          r_cst;
  state_t          w_nst;
  logic            r_reqD;
  logic            w_reqX;
  logic            w_done;
  logic [2*W-1:0]  r_p;
  logic [2*W-1:0]  r_a;
  logic [W-1:0]    r_b;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_tx;

  assign w_reqX = bus.req ^ r_reqD;

`ifdef MUL_EARLY_EXIT_EN
  assign w_done = (r_cnt == CW'(W)) || (r_b == '0);
`else
  assign w_done = (r_cnt == CW'(W));
`endif

  always_comb begin
    w_nst = ST_IDLE;
    case (r_cst)
      ST_IDLE: w_nst = w_reqX ? ST_LOAD : ST_IDLE;
      ST_LOAD: w_nst = ST_IF;
      ST_IF:   w_nst = w_done ? ST_IDLE : ST_CALC;
      ST_CALC: w_nst = ST_IF;
      default: w_nst = ST_IDLE;
    endcase
  end

  // Datapath is keyed on the next state so each register updates on the edge that enters that state.
  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      r_reqD <= 1'b0;
      r_cst  <= ST_IDLE;
      r_p    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_tx   <= '0;
    end else if (bus.enable) begin
      r_reqD <= bus.req;
      r_cst  <= w_nst;
      case (w_nst)
        ST_LOAD: begin
          r_p   <= '0;
          r_a   <= {{W{1'b0}}, bus.rx_data_1};
          r_b   <= bus.rx_data_2;
          r_cnt <= '0;
        end
        ST_CALC: begin
          if (r_b[0]) begin
            r_p <= r_p + r_a;
          end
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_IDLE: begin
          r_tx <= r_p;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ack     = (r_cst == ST_IDLE);
  assign bus.cst     = r_cst;
  assign bus.nst     = w_nst;
  assign bus.tx_data = r_tx;

endmodule

// File: tb/tb_mul_sa.sv
// Directed self-checking bench for mul_sa: vector table of products and latencies
// plus hand-written sequences for handshake, enable, pending-toggle and reset corners.
module tb_mul_sa;

  logic clk0;
  logic rstn;
  int   compared;
  int   mismatched;
  logic [15:0] lastProd;
  bit   holdBad;

  mul_sa_if #(.MSB(7)) bus ();

  mul_sa #(.MSB(7)) dut (
    .clk0 (clk0),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  // Reference latency in enabled edges, counting the edge that samples the toggle.
  function automatic int expLat(logic [7:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) k = i + 1;
    end
    return 2 * k + 3;
`else
    return 19;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    bus.rx_data_1 = a;
    bus.rx_data_2 = b;
    bus.req       = ~bus.req;
  endtask

  // Counts negedges until ack is seen high; tx_data must keep the previous product while busy.
  task automatic waitDone(input int start, output int edges);
    edges = start;
    do begin
      @(negedge clk0);
      edges++;
      if (bus.ack === 1'b0 && bus.tx_data !== lastProd) holdBad = 1'b1;
    end while (bus.ack !== 1'b1 && edges < 200);
    if (bus.ack !== 1'b1) checkOutput("timeout", 32'(bus.ack), 32'd1);
  endtask

  task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] prod, input int extra);
    int edges;
    holdBad = 1'b0;
    applyStimulus(a, b);
    @(negedge clk0);
    checkOutput({name, "_ackfall"}, 32'(bus.ack), 32'd0);
    if (bus.tx_data !== lastProd) holdBad = 1'b1;
    waitDone(1, edges);
    checkOutput({name, "_lat"}, 32'(edges), 32'(expLat(b) + extra));
    checkOutput({name, "_prod"}, 32'(bus.tx_data), 32'(prod));
    checkOutput({name, "_hold"}, 32'(holdBad), 32'd0);
    lastProd = prod;
  endtask

  initial begin
    vec_t vecs[10];
    int   edges;
    bit   flag;

    compared   = 0;
    mismatched = 0;
    lastProd   = 16'h0000;
    holdBad    = 1'b0;

    vecs[0] = '{"d_0Dx0B", 8'h0D, 8'h0B, 16'h008F};
    vecs[1] = '{"d_FFxFF", 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{"d_00xA5", 8'h00, 8'hA5, 16'h0000};
    vecs[3] = '{"d_80x02", 8'h80, 8'h02, 16'h0100};
    vecs[4] = '{"d_A5x3C", 8'hA5, 8'h3C, 16'h26AC};
    vecs[5] = '{"d_01xFF", 8'h01, 8'hFF, 16'h00FF};
    vecs[6] = '{"d_5Ax01", 8'h5A, 8'h01, 16'h005A};
    vecs[7] = '{"d_12x00", 8'h12, 8'h00, 16'h0000};
    vecs[8] = '{"d_80x80", 8'h80, 8'h80, 16'h4000};
    vecs[9] = '{"d_07x09", 8'h07, 8'h09, 16'h003F};

    // Reset with random inputs
    rstn          = 1'b0;
    bus.enable    = 1'($urandom);
    bus.req       = 1'($urandom);
    bus.rx_data_1 = 8'($urandom);
    bus.rx_data_2 = 8'($urandom);
    repeat (3) @(negedge clk0);
    checkOutput("rst_tx", 32'(bus.tx_data), 32'h0000);
    checkOutput("rst_cst", 32'(bus.cst), 32'd0);
    checkOutput("rst_ack", 32'(bus.ack), 32'd1);

    bus.req    = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk0);
    rstn = 1'b1;
    flag = 1'b0;
    repeat (12) begin
      @(negedge clk0);
      if (bus.ack !== 1'b1 || bus.cst !== 2'b00) flag = 1'b1;
    end
    checkOutput("idle_noreq", 32'(flag), 32'd0);

    $display("[TB] running %0d table vectors", 10);
    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].prod, 0);
      repeat (2) @(negedge clk0);
      checkOutput({vecs[i].name, "_stay"}, 32'(bus.tx_data), 32'(vecs[i].prod));
    end

    // Extra toggles and operand changes while busy are dropped
    holdBad = 1'b0;
    applyStimulus(8'h12, 8'h34);
    @(negedge clk0);
    bus.req       = ~bus.req;
    bus.rx_data_1 = 8'hFF;
    bus.rx_data_2 = 8'hFF;
    @(negedge clk0);
    @(negedge clk0);
    bus.req       = ~bus.req;
    bus.rx_data_1 = 8'h00;
    waitDone(3, edges);
    checkOutput("dbl_lat", 32'(edges), 32'(expLat(8'h34)));
    checkOutput("dbl_prod", 32'(bus.tx_data), 32'h03A8);
    lastProd = 16'h03A8;
    flag = 1'b0;
    repeat (25) begin
      @(negedge clk0);
      if (bus.ack !== 1'b1 || bus.tx_data !== 16'h03A8) flag = 1'b1;
    end
    checkOutput("dbl_single", 32'(flag), 32'd0);

    // Enable dropped mid-calculation for 5 cycles
    holdBad = 1'b0;
    applyStimulus(8'h0D, 8'hFB);
    repeat (6) @(negedge clk0);
    bus.enable = 1'b0;
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk0);
      if (bus.ack !== 1'b0 || bus.cst !== 2'b11) flag = 1'b1;
    end
    checkOutput("en_frozen", 32'(flag), 32'd0);
    bus.enable = 1'b1;
    waitDone(11, edges);
    checkOutput("en_lat", 32'(edges), 32'(expLat(8'hFB) + 5));
    checkOutput("en_prod", 32'(bus.tx_data), 32'h0CBF);
    lastProd = 16'h0CBF;

    // Toggle made while disabled stays pending
    bus.enable = 1'b0;
    applyStimulus(8'h03, 8'h05);
    repeat (3) @(negedge clk0);
    checkOutput("pend_idle", 32'(bus.ack), 32'd1);
    bus.enable = 1'b1;
    waitDone(0, edges);
    checkOutput("pend_lat", 32'(edges), 32'(expLat(8'h05)));
    checkOutput("pend_prod", 32'(bus.tx_data), 32'h000F);
    lastProd = 16'h000F;

    // Reset in st_calc with cnt=4 (9th edge after the toggle)
    applyStimulus(8'h5A, 8'h77);
    repeat (9) @(negedge clk0);
    checkOutput("mid_cst", 32'(bus.cst), 32'd2);
    rstn    = 1'b0;
    bus.req = 1'b0;
    #1;
    checkOutput("mid_rst_cst", 32'(bus.cst), 32'd0);
    checkOutput("mid_rst_ack", 32'(bus.ack), 32'd1);
    checkOutput("mid_rst_tx", 32'(bus.tx_data), 32'h0000);
    @(negedge clk0);
    rstn     = 1'b1;
    lastProd = 16'h0000;
    @(negedge clk0);
    runOp("post_rst", 8'h07, 8'h09, 16'h003F, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
